proc_resp_queue: RTL and testbench

- Response buffer that sits directly downstream of the processor's memory-response drop stage and feeds the writeback/M-stage consumer.
- Circular-buffer FIFO with val/rdy on both sides.
- Decouples the memory system from pipeline stalls.
- Carries a flush input so a squash can discard buffered late responses in one cycle.

---
 rtl/proc_resp_queue_pkg.sv | 25 ++
 rtl/proc_resp_queue_ctrl.sv | 81 ++++++++
 rtl/proc_resp_queue.sv | 53 +++++
 tb/tb_proc_resp_queue.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/proc_resp_queue_pkg.sv
// Shared types and sizing helpers for the processor memory-response queue.
package proc_resp_queue_pkg;

    // Memory response message in the existing mem response field order.
    typedef struct packed {
        logic [2:0]  typ;
        logic [7:0]  opaque;
        logic [1:0]  test;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_resp_t;

    localparam int unsigned MEM_RESP_NBITS = $bits(mem_resp_t);

    // Pointer width; never less than one bit.
    function automatic int unsigned ptr_nbits(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width able to hold 0..n inclusive.
    function automatic int unsigned cnt_nbits(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/proc_resp_queue_ctrl.sv
// Pointer/count control for the response queue: handshakes, flush and optional
// empty-queue bypass (PROC_RESP_QUEUE_BYPASS_EN).
module proc_resp_queue_ctrl
    import proc_resp_queue_pkg::*;
#(
    parameter int unsigned p_num_entries = 2
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   flush,
    input  logic                                   enq_val,
    input  logic                                   deq_rdy,
    output logic                                   enq_rdy,
    output logic                                   deq_val,
    output logic                                   wen,
    output logic [ptr_nbits(p_num_entries)-1:0]    waddr,
    output logic [ptr_nbits(p_num_entries)-1:0]    raddr,
    output logic                                   bypass,
    output logic [cnt_nbits(p_num_entries)-1:0]    num_free
);

    localparam int unsigned PW = ptr_nbits(p_num_entries);
    localparam int unsigned CW = cnt_nbits(p_num_entries);

    logic [PW-1:0] enq_ptr, enq_ptr_next;
    logic [PW-1:0] deq_ptr, deq_ptr_next;
    logic [CW-1:0] count, count_next;
    logic          full, empty, push, pop, byp;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(p_num_entries - 1)) ? '0 : p + PW'(1);
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            enq_ptr <= '0;
            deq_ptr <= '0;
            count   <= '0;
        end else begin
            enq_ptr <= enq_ptr_next;
            deq_ptr <= deq_ptr_next;
            count   <= count_next;
        end
    end

    // Handshakes and next-state
    always_comb begin
        full  = (count == CW'(p_num_entries));
        empty = (count == '0);
        byp   = 1'b0;
`ifdef PROC_RESP_QUEUE_BYPASS_EN
        byp   = !reset && !flush && empty && enq_val;
`endif
        enq_rdy = !reset && (flush || !full);
        deq_val = !reset && !flush && (!empty || byp);
        // A bypassed message that is consumed immediately never touches storage.
        push    = enq_val && enq_rdy && !flush && !(byp && deq_rdy);
        pop     = deq_val && deq_rdy && !empty;

        enq_ptr_next = enq_ptr;
        deq_ptr_next = deq_ptr;
        count_next   = count;
        if (flush) begin
            enq_ptr_next = '0;
            deq_ptr_next = '0;
            count_next   = '0;
        end else begin
            if (push) enq_ptr_next = ptr_inc(enq_ptr);
            if (pop)  deq_ptr_next = ptr_inc(deq_ptr);
            count_next = count + CW'(push) - CW'(pop);
        end
    end

    assign wen      = push;
    assign waddr    = enq_ptr;
    assign raddr    = deq_ptr;
    assign bypass   = byp;
    assign num_free = CW'(p_num_entries) - count;

endmodule

// File: rtl/proc_resp_queue.sv
// Circular-buffer response queue between the memory-response drop stage and
// writeback. Optional zero-latency empty bypass: PROC_RESP_QUEUE_BYPASS_EN.
module proc_resp_queue
    import proc_resp_queue_pkg::*;
#(
    parameter int unsigned p_msg_nbits   = 32,
    parameter int unsigned p_num_entries = 2
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                flush,
    input  logic [p_msg_nbits-1:0]              enq_msg,
    input  logic                                enq_val,
    output logic                                enq_rdy,
    output logic [p_msg_nbits-1:0]              deq_msg,
    output logic                                deq_val,
    input  logic                                deq_rdy,
    output logic [cnt_nbits(p_num_entries)-1:0] num_free
);

    localparam int unsigned PW = ptr_nbits(p_num_entries);

    logic                   wen;
    logic                   bypass;
    logic [PW-1:0]          waddr;
    logic [PW-1:0]          raddr;
    logic [p_msg_nbits-1:0] entries [p_num_entries];

    proc_resp_queue_ctrl #(
        .p_num_entries (p_num_entries)
    ) u_ctrl (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .enq_val  (enq_val),
        .deq_rdy  (deq_rdy),
        .enq_rdy  (enq_rdy),
        .deq_val  (deq_val),
        .wen      (wen),
        .waddr    (waddr),
        .raddr    (raddr),
        .bypass   (bypass),
        .num_free (num_free)
    );

    // Entry storage; contents need no reset.
    always_ff @(posedge clk) begin
        if (wen) entries[waddr] <= enq_msg;
    end

    assign deq_msg = bypass ? enq_msg : entries[raddr];

endmodule

// File: tb/tb_proc_resp_queue.sv
// Randomized + directed bench for proc_resp_queue with a queue-based reference model.
module tb_proc_resp_queue;
    import proc_resp_queue_pkg::*;

    localparam int unsigned N  = 2;
    localparam int unsigned W  = 32;
    localparam int unsigned CW = cnt_nbits(N);

    logic          clk, reset, flush, enq_val, enq_rdy, deq_val, deq_rdy;
    logic [W-1:0]  enq_msg, deq_msg;
    logic [CW-1:0] num_free;

    int checks = 0;
    int errors = 0;
    int deq_cnt = 0;
    logic [W-1:0] sb [$];

    bit           e_rdy, e_val, e_byp;
    logic [W-1:0] e_msg;

    proc_resp_queue #(.p_msg_nbits(W), .p_num_entries(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .enq_msg  (enq_msg),
        .enq_val  (enq_val),
        .enq_rdy  (enq_rdy),
        .deq_msg  (deq_msg),
        .deq_val  (deq_val),
        .deq_rdy  (deq_rdy),
        .num_free (num_free)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: expected behaviour comes from the model queue, never from the DUT.
    always @(negedge clk) begin
        if (reset) begin
            chk("rst_enq_rdy", 32'(enq_rdy), 32'd0);
            chk("rst_deq_val", 32'(deq_val), 32'd0);
            sb.delete();
        end else begin
            e_rdy = flush || (sb.size() < N);
`ifdef PROC_RESP_QUEUE_BYPASS_EN
            e_val = !flush && (sb.size() > 0 || enq_val);
`else
            e_val = !flush && (sb.size() > 0);
`endif
            chk("enq_rdy", 32'(enq_rdy), 32'(e_rdy));
            chk("deq_val", 32'(deq_val), 32'(e_val));
            chk("num_free", 32'(num_free), 32'(N - sb.size()));
            if (flush) begin
                sb.delete();
            end else begin
                e_byp = 1'b0;
                if (e_val && deq_rdy) begin
                    if (sb.size() == 0) begin
                        e_msg = enq_msg;
                        e_byp = 1'b1;
                    end else begin
                        e_msg = sb.pop_front();
                    end
                    chk("deq_msg", deq_msg, e_msg);
                    deq_cnt++;
                end
                if (enq_val && e_rdy && !e_byp) sb.push_back(enq_msg);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enq_one(input logic [W-1:0] m);
        enq_val = 1'b1;
        enq_msg = m;
        tick();
        enq_val = 1'b0;
    endtask

    int start_cnt;
    int max_occ;

    initial begin
        reset = 1'b1; flush = 1'b0; enq_val = 1'b0; enq_msg = '0; deq_rdy = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        repeat (3) tick();

        // Fill then drain
        enq_one(32'hA0);
        enq_one(32'hA1);
        tick();
        deq_rdy = 1'b1;
        repeat (3) tick();

        // Back-to-back streaming
        start_cnt = deq_cnt;
        max_occ = 0;
        for (int i = 0; i < 16; i++) begin
            enq_val = 1'b1;
            enq_msg = 32'h10 + 32'(i);
            tick();
            if (int'(N) - int'(num_free) > max_occ) max_occ = int'(N) - int'(num_free);
        end
        enq_val = 1'b0;
        repeat (2) tick();
        chk("stream_deq_count", 32'(deq_cnt - start_cnt), 32'd16);
        chk("stream_max_occ_le1", 32'(max_occ <= 1), 32'd1);

        // Full with simultaneous dequeue
        deq_rdy = 1'b0;
        enq_one(32'hB0);
        enq_one(32'hB1);
        enq_val = 1'b1; enq_msg = 32'hB2; deq_rdy = 1'b1;
        repeat (2) tick();
        enq_val = 1'b0;
        repeat (3) tick();

        // Flush discards contents and same-cycle enqueue
        deq_rdy = 1'b0;
        enq_one(32'hC0);
        enq_one(32'hC1);
        flush = 1'b1; enq_val = 1'b1; enq_msg = 32'hC2;
        tick();
        flush = 1'b0; enq_val = 1'b0;
        tick();
        enq_one(32'hC3);
        deq_rdy = 1'b1;
        repeat (2) tick();

        // Enqueue into empty queue with consumer ready
        enq_one(32'hD0);
        repeat (2) tick();

        // Random traffic including flushes and mid-operation resets
        for (int i = 0; i < 3000; i++) begin
            reset   = ($urandom_range(0, 299) == 0);
            flush   = ($urandom_range(0, 15) == 0);
            enq_val = $urandom_range(0, 1) != 0;
            enq_msg = $urandom;
            deq_rdy = $urandom_range(0, 3) != 0;
            tick();
        end
        reset = 1'b0; flush = 1'b0; enq_val = 1'b0; deq_rdy = 1'b1;
        for (int k = 0; k < 20 && sb.size() > 0; k++) tick();
        tick();
        chk("drain_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
